armleocpu_ptw: RTL and testbench

//  Sv32 page-table walker; the refill side of armleocpu_tlb. On a TLB miss it reads the
//  two-level page table over a memory read port, checks the PTE and produces a result.
//  On a valid leaf it issues exactly one TLB_CMD_WRITE cycle on the TLB write port.

---
 rtl/armleocpu_ptw.sv | 172 +++++++++++++++++
 tb/tb_armleocpu_ptw.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_ptw.sv
// Sv32 page-table walker: two-level PTE fetch over a read port, leaf/fault
// classification, and a single-cycle TLB write on a successful leaf.
module armleocpu_ptw #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    output logic        resolve_ack,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [21:0] resolve_physical_address,
    output logic [7:0]  resolve_access_bits,
    input  logic        satp_mode,
    input  logic [21:0] satp_ppn,
    output logic [33:0] m_address,
    output logic        m_read,
    input  logic        m_readdone,
    input  logic        m_readerror,
    input  logic [31:0] m_readdata,
    output logic [1:0]  tlb_command,
    output logic [19:0] tlb_virtual_address_w,
    output logic [7:0]  tlb_accesstag_w,
    output logic [21:0] tlb_phys_w
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_L1     = 2'd1;
    localparam logic [1:0] S_L0     = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [1:0] TLB_CMD_NONE  = 2'b00;
    localparam logic [1:0] TLB_CMD_WRITE = 2'b11;

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [1:0]    state_q, state_d;
    logic [19:0]   va_q, va_d;
    logic [21:0]   root_q, root_d;
    logic [21:0]   pte_ppn_q, pte_ppn_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [21:0]   res_ppn_q, res_ppn_d;
    logic [7:0]    res_bits_q, res_bits_d;
    logic          pf_q, pf_d, af_q, af_d, wr_q, wr_d;
    logic          ack;

    // RSW bits carry no meaning for the walk
    logic unused_rsw;
    assign unused_rsw = ^m_readdata[9:8];

    wire pte_v = m_readdata[0];
    wire pte_r = m_readdata[1];
    wire pte_w = m_readdata[2];
    wire pte_x = m_readdata[3];

    always_comb begin
        state_d    = state_q;
        va_d       = va_q;
        root_d     = root_q;
        pte_ppn_d  = pte_ppn_q;
        cnt_d      = cnt_q;
        res_ppn_d  = res_ppn_q;
        res_bits_d = res_bits_q;
        pf_d       = pf_q;
        af_d       = af_q;
        wr_d       = wr_q;
        ack        = 1'b0;
        case (state_q)
            S_IDLE: if (resolve_request && !rst) begin
                ack    = 1'b1;
                va_d   = resolve_virtual_address;
                root_d = satp_ppn;
                pf_d   = 1'b0;
                af_d   = 1'b0;
                wr_d   = 1'b0;
                cnt_d  = '0;
                if (satp_mode) begin
                    state_d = S_L1;
                end else begin
                    res_ppn_d  = {2'b00, resolve_virtual_address};
                    res_bits_d = 8'hCF;
                    state_d    = S_RESULT;
                end
            end
            S_L1, S_L0: begin
                if (m_readdone) begin
                    cnt_d = '0;
                    if (m_readerror) begin
                        af_d    = 1'b1;
                        state_d = S_RESULT;
                    end else if (!pte_v || (!pte_r && pte_w)) begin
                        pf_d    = 1'b1;
                        state_d = S_RESULT;
                    end else if (pte_r || pte_x) begin
                        state_d    = S_RESULT;
                        res_bits_d = m_readdata[7:0];
                        if (state_q == S_L1) begin
                            if (m_readdata[19:10] != 10'd0) begin
                                pf_d = 1'b1;
                            end else begin
                                res_ppn_d = {m_readdata[31:20], va_q[9:0]};
                                wr_d      = 1'b1;
                            end
                        end else begin
                            res_ppn_d = m_readdata[31:10];
                            wr_d      = 1'b1;
                        end
                    end else if (state_q == S_L1) begin
                        pte_ppn_d = m_readdata[31:10];
                        state_d   = S_L0;
                    end else begin
                        pf_d    = 1'b1;
                        state_d = S_RESULT;
                    end
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    af_d    = 1'b1;
                    state_d = S_RESULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            va_q       <= '0;
            root_q     <= '0;
            pte_ppn_q  <= '0;
            cnt_q      <= '0;
            res_ppn_q  <= '0;
            res_bits_q <= '0;
            pf_q       <= 1'b0;
            af_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            va_q       <= va_d;
            root_q     <= root_d;
            pte_ppn_q  <= pte_ppn_d;
            cnt_q      <= cnt_d;
            res_ppn_q  <= res_ppn_d;
            res_bits_q <= res_bits_d;
            pf_q       <= pf_d;
            af_q       <= af_d;
            wr_q       <= wr_d;
        end
    end

    always_comb begin
        m_address = '0;
        if (state_q == S_L1)
            m_address = {root_q, 12'h000} + {22'd0, va_q[19:10], 2'b00};
        else if (state_q == S_L0)
            m_address = {pte_ppn_q, 12'h000} + {22'd0, va_q[9:0], 2'b00};
    end

    assign resolve_ack              = ack;
    assign resolve_done             = (state_q == S_RESULT);
    assign resolve_pagefault        = resolve_done & pf_q;
    assign resolve_accessfault      = resolve_done & af_q;
    assign resolve_physical_address = res_ppn_q;
    assign resolve_access_bits      = res_bits_q;
    assign m_read                   = (state_q == S_L1) || (state_q == S_L0);
    assign tlb_command              = (resolve_done && wr_q) ? TLB_CMD_WRITE : TLB_CMD_NONE;
    assign tlb_virtual_address_w    = va_q;
    assign tlb_accesstag_w          = res_bits_q;
    assign tlb_phys_w               = res_ppn_q;
endmodule

// File: tb/tb_armleocpu_ptw.sv
// Bench for armleocpu_ptw: table vectors, directed multi-cycle sequences and
// random page tables checked against a level-loop reference walk.
module tb_armleocpu_ptw;
    localparam logic [1:0] CMD_WRITE = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [19:0] vaddr;
    logic        resolve_ack, resolve_done, resolve_pagefault, resolve_accessfault;
    logic [21:0] resolve_physical_address;
    logic [7:0]  resolve_access_bits;
    logic        satp_mode;
    logic [21:0] satp_ppn;
    logic [33:0] m_address;
    logic        m_read;
    logic        m_readdone, m_readerror;
    logic [31:0] m_readdata;
    logic [1:0]  tlb_command;
    logic [19:0] tlb_virtual_address_w;
    logic [7:0]  tlb_accesstag_w;
    logic [21:0] tlb_phys_w;

    armleocpu_ptw #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .resolve_request(req), .resolve_virtual_address(vaddr),
        .resolve_ack(resolve_ack), .resolve_done(resolve_done),
        .resolve_pagefault(resolve_pagefault), .resolve_accessfault(resolve_accessfault),
        .resolve_physical_address(resolve_physical_address),
        .resolve_access_bits(resolve_access_bits),
        .satp_mode(satp_mode), .satp_ppn(satp_ppn),
        .m_address(m_address), .m_read(m_read), .m_readdone(m_readdone),
        .m_readerror(m_readerror), .m_readdata(m_readdata),
        .tlb_command(tlb_command), .tlb_virtual_address_w(tlb_virtual_address_w),
        .tlb_accesstag_w(tlb_accesstag_w), .tlb_phys_w(tlb_phys_w)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [logic [33:0]];
    logic [33:0] err_addr = '1;
    int          mem_lat  = 1;
    logic        mute     = 1'b0;

    typedef struct {
        logic        acked, done, pf, af;
        logic [21:0] phys;
        logic [7:0]  bits;
        int          nwr, lat, nreads, nrdcyc;
        logic [19:0] wva;
        logic [21:0] wphys;
        logic [7:0]  wbits;
    } walk_t;

    typedef struct {
        logic        pf, af, wr;
        logic [21:0] phys;
        logic [7:0]  bits;
        int          reads;
    } model_t;

    typedef struct {
        logic [31:0] pte1, pte0;
        int          err_lvl;
        logic        pf, af;
        logic [21:0] phys;
        logic [7:0]  bits;
        int          wr, reads;
    } vec_t;

    function automatic logic [31:0] rd(input logic [33:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Memory: answers a held read after mem_lat cycles, data from the table.
    initial begin
        int cnt;
        cnt = 0;
        m_readdone = 1'b0; m_readerror = 1'b0; m_readdata = '0;
        forever begin
            @(negedge clk);
            m_readdone = 1'b0; m_readerror = 1'b0; m_readdata = $urandom;
            if (m_read && !mute) begin
                if (cnt >= mem_lat) begin
                    m_readdone  = 1'b1;
                    m_readdata  = rd(m_address);
                    m_readerror = (m_address == err_addr);
                    cnt = 0;
                end else cnt++;
            end else cnt = 0;
        end
    end

    // Sv32 walk computed level by level from the page-table contents.
    function automatic model_t model(input logic [19:0] va, input logic [21:0] root);
        model_t      m;
        logic [21:0] base;
        logic [33:0] a;
        logic [31:0] p;
        m = '{default: 0};
        base = root;
        for (int lvl = 1; lvl >= 0; lvl--) begin
            a = {base, 12'h000} + 34'(lvl == 1 ? va[19:10] : va[9:0]) * 34'd4;
            m.reads++;
            if (a == err_addr) begin m.af = 1'b1; return m; end
            p = rd(a);
            if (!p[0] || (p[2] && !p[1])) begin m.pf = 1'b1; return m; end
            if (p[1] || p[3]) begin
                if (lvl == 1 && p[19:10] != 10'd0) begin m.pf = 1'b1; return m; end
                m.phys = (lvl == 1) ? {p[31:20], va[9:0]} : p[31:10];
                m.bits = p[7:0];
                m.wr   = 1'b1;
                return m;
            end
            base = p[31:10];
        end
        m.pf = 1'b1;
        return m;
    endfunction

    task automatic walk(input logic [19:0] va, input logic [21:0] root, input logic mode,
                        output walk_t r);
        r = '{default: 0};
        @(negedge clk);
        req = 1'b1; vaddr = va; satp_ppn = root; satp_mode = mode;
        #1 r.acked = resolve_ack;
        for (int c = 1; c < 400; c++) begin
            @(negedge clk);
            req = 1'b0;
            #1;
            if (m_read) r.nrdcyc++;
            if (m_read && m_readdone) r.nreads++;
            if (tlb_command == CMD_WRITE) begin
                r.nwr++;
                r.wva = tlb_virtual_address_w; r.wphys = tlb_phys_w; r.wbits = tlb_accesstag_w;
            end
            if (resolve_done) begin
                r.done = 1'b1; r.lat = c;
                r.pf = resolve_pagefault; r.af = resolve_accessfault;
                r.phys = resolve_physical_address; r.bits = resolve_access_bits;
                break;
            end
        end
    endtask

    task automatic setup_vec(input logic [31:0] p1, input logic [31:0] p0, input int el);
        logic [33:0] a1, a0;
        mem.delete();
        a1 = 34'h10120;
        a0 = {p1[31:10], 12'h000} + 34'h0D14;
        mem[a1] = p1;
        mem[a0] = p0;
        err_addr = (el == 1) ? a1 : (el == 0) ? a0 : '1;
    endtask

    initial begin
        vec_t   vt[8];
        walk_t  r;
        model_t m;
        int     acks, ack2, dcyc, seen, n;

        vt[0] = '{32'h00020001, 32'h2AF378CF, -1, 1'b0, 1'b0, 22'h0ABCDE, 8'hCF, 1, 2};
        vt[1] = '{32'h100000CF, 32'h00000000, -1, 1'b0, 1'b0, 22'h040345, 8'hCF, 1, 1};
        vt[2] = '{32'h100004CF, 32'h00000000, -1, 1'b1, 1'b0, 22'h0, 8'h0, 0, 1};
        vt[3] = '{32'h00000000, 32'h00000000, -1, 1'b1, 1'b0, 22'h0, 8'h0, 0, 1};
        vt[4] = '{32'h00000005, 32'h00000000, -1, 1'b1, 1'b0, 22'h0, 8'h0, 0, 1};
        vt[5] = '{32'h00020001, 32'h00020001, -1, 1'b1, 1'b0, 22'h0, 8'h0, 0, 2};
        vt[6] = '{32'h00020001, 32'h2AF378CF,  0, 1'b0, 1'b1, 22'h0, 8'h0, 0, 2};
        vt[7] = '{32'h00020001, 32'h2AF378CF,  1, 1'b0, 1'b1, 22'h0, 8'h0, 0, 1};

        rst = 1'b1; req = 1'b1; vaddr = 20'h12345; satp_mode = 1'b1; satp_ppn = 22'h10;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_ack", 64'(resolve_ack), 64'd0);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_done", 64'(resolve_done), 64'd0);
        chk("rst_mread", 64'(m_read), 64'd0);
        chk("rst_maddr", 64'(m_address), 64'd0);
        chk("rst_tlbcmd", 64'(tlb_command), 64'd0);
        chk("rst_phys", 64'(resolve_physical_address), 64'd0);
        chk("rst_bits", 64'(resolve_access_bits), 64'd0);

        foreach (vt[i]) begin
            setup_vec(vt[i].pte1, vt[i].pte0, vt[i].err_lvl);
            mem_lat = 1;
            walk(20'h12345, 22'h10, 1'b1, r);
            chk($sformatf("vec%0d_ack", i), 64'(r.acked), 64'd1);
            chk($sformatf("vec%0d_done", i), 64'(r.done), 64'd1);
            chk($sformatf("vec%0d_pf", i), 64'(r.pf), 64'(vt[i].pf));
            chk($sformatf("vec%0d_af", i), 64'(r.af), 64'(vt[i].af));
            chk($sformatf("vec%0d_nwr", i), 64'(r.nwr), 64'(vt[i].wr));
            chk($sformatf("vec%0d_reads", i), 64'(r.nreads), 64'(vt[i].reads));
            if (vt[i].wr != 0) begin
                chk($sformatf("vec%0d_phys", i), 64'(r.phys), 64'(vt[i].phys));
                chk($sformatf("vec%0d_bits", i), 64'(r.bits), 64'(vt[i].bits));
                chk($sformatf("vec%0d_wva", i), 64'(r.wva), 64'h12345);
                chk($sformatf("vec%0d_wphys", i), 64'(r.wphys), 64'(vt[i].phys));
                chk($sformatf("vec%0d_wbits", i), 64'(r.wbits), 64'(vt[i].bits));
            end
            if (i == 0) chk("vec0_latency", 64'(r.lat), 64'd5);
        end

        err_addr = '1;
        walk(20'hABCDE, 22'h10, 1'b0, r);
        chk("bare_lat", 64'(r.lat), 64'd1);
        chk("bare_phys", 64'(r.phys), 64'h0ABCDE);
        chk("bare_bits", 64'(r.bits), 64'hCF);
        chk("bare_nwr", 64'(r.nwr), 64'd0);
        chk("bare_fault", 64'({r.pf, r.af}), 64'd0);

        mute = 1'b1;
        walk(20'h12345, 22'h10, 1'b1, r);
        chk("tmo_af", 64'(r.af), 64'd1);
        chk("tmo_pf", 64'(r.pf), 64'd0);
        chk("tmo_mread_cycles", 64'(r.nrdcyc), 64'd16);
        chk("tmo_lat", 64'(r.lat), 64'd17);
        chk("tmo_nwr", 64'(r.nwr), 64'd0);
        @(negedge clk); #2;
        m_readdone = 1'b1; m_readerror = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (resolve_done || m_read || tlb_command != 2'b00) seen++;
        end
        chk("late_readdone_ignored", 64'(seen), 64'd0);
        mute = 1'b0;

        // reset in the middle of the L0 read
        setup_vec(32'h00020001, 32'h2AF378CF, -1);
        @(negedge clk);
        req = 1'b1; vaddr = 20'h12345; satp_ppn = 22'h10; satp_mode = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk); req = 1'b0; #1;
            if (m_read && m_address == 34'h80D14) begin seen = 1; break; end
        end
        chk("midrst_reached_l0", 64'(seen), 64'd1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        chk("midrst_mread", 64'(m_read), 64'd0);
        n = 0;
        repeat (8) begin
            if (resolve_done || tlb_command != 2'b00 || m_read) n++;
            @(negedge clk); #1;
        end
        chk("midrst_quiet", 64'(n), 64'd0);

        // request held across a walk
        setup_vec(32'h00020001, 32'h2AF378CF, -1);
        acks = 0; ack2 = -1; dcyc = -1;
        @(negedge clk);
        req = 1'b1; vaddr = 20'h12345; satp_ppn = 22'h10; satp_mode = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (resolve_ack) begin acks++; if (c != 0) ack2 = c; end
            if (resolve_done && dcyc < 0) dcyc = c;
            @(negedge clk);
        end
        req = 1'b0;
        chk("hold_first_done", 64'(dcyc), 64'd5);
        chk("hold_ack_count", 64'(acks), 64'd2);
        chk("hold_second_ack", 64'(ack2), 64'd6);
        repeat (3) @(negedge clk);

        for (int it = 0; it < 40; it++) begin
            logic [21:0] root;
            logic [19:0] va;
            logic [33:0] a1, a0;
            logic [31:0] p1, p0;
            int          k;
            root = 22'($urandom); va = 20'($urandom);
            mem.delete();
            a1 = {root, 12'h000} + 34'(va[19:10]) * 34'd4;
            p1 = $urandom;
            k = $urandom_range(0, 9);
            if (k < 5) p1[3:0] = 4'b0001;
            else if (k < 7) begin p1[19:10] = 10'd0; p1[1:0] = 2'b11; end
            mem[a1] = p1;
            a0 = {p1[31:10], 12'h000} + 34'(va[9:0]) * 34'd4;
            p0 = $urandom;
            if ($urandom_range(0, 3) != 0) p0[0] = 1'b1;
            if (!mem.exists(a0)) mem[a0] = p0;
            k = $urandom_range(0, 9);
            err_addr = (k == 0) ? a1 : (k == 1) ? a0 : '1;
            mem_lat = $urandom_range(1, 4);
            m = model(va, root);
            walk(va, root, 1'b1, r);
            chk($sformatf("rnd%0d_done", it), 64'(r.done), 64'd1);
            chk($sformatf("rnd%0d_pf", it), 64'(r.pf), 64'(m.pf));
            chk($sformatf("rnd%0d_af", it), 64'(r.af), 64'(m.af));
            chk($sformatf("rnd%0d_nwr", it), 64'(r.nwr), 64'(m.wr));
            chk($sformatf("rnd%0d_reads", it), 64'(r.nreads), 64'(m.reads));
            if (m.wr) begin
                chk($sformatf("rnd%0d_phys", it), 64'(r.phys), 64'(m.phys));
                chk($sformatf("rnd%0d_bits", it), 64'(r.bits), 64'(m.bits));
                chk($sformatf("rnd%0d_wva", it), 64'(r.wva), 64'(va));
                chk($sformatf("rnd%0d_wphys", it), 64'(r.wphys), 64'(m.phys));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule
